// File: rtl/reg_bank_rw.sv
// -----------------------------------------------------------------------------
// reg_bank_rw
//   32-entry general-purpose register bank for the multicycle MIPS datapath.
//   One synchronous write port, two combinational read ports (rs/rt), and
//   direct taps of $sp (r29) and $ra (r31).
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous reset, active-low
//   reg_write   write enable, sampled at rising clk
//   write_reg   destination register index (5 bits)
//   write_data  data to write (DATA_W bits)
//   read_reg1   source index 1 (rs)
//   read_reg2   source index 2 (rt)
//   read_data1  contents of read_reg1 (optionally forwarded from write port)
//   read_data2  contents of read_reg2 (optionally forwarded from write port)
//   sp_out      stored contents of register 29, never forwarded
//   ra_out      stored contents of register 31, never forwarded
// -----------------------------------------------------------------------------
module reg_bank_rw #(
  parameter int                 DATA_W  = 32,
  parameter logic [DATA_W-1:0]  SP_INIT = 227,
  parameter logic [DATA_W-1:0]  RA_INIT = 0,
  parameter int                 BYPASS  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [4:0]        write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [4:0]        read_reg1,
  input  logic [4:0]        read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] sp_out,
  output logic [DATA_W-1:0] ra_out
);

  localparam logic [4:0] ZERO_IDX = 5'd0;
  localparam logic [4:0] SP_IDX   = 5'd29;
  localparam logic [4:0] RA_IDX   = 5'd31;

  logic [DATA_W-1:0] regs_r [32];
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;
  logic              fwd_en_s;

  // Reset image of one register: $sp and $ra have their own start values.
  function automatic logic [DATA_W-1:0] reset_value(input logic [4:0] idx);
    logic [DATA_W-1:0] val;
    case (idx)
      SP_IDX:  val = SP_INIT;
      RA_IDX:  val = RA_INIT;
      default: val = {DATA_W{1'b0}};
    endcase
    return val;
  endfunction

  // Register storage: async reset image, single write port, r0 never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= reset_value(5'(i));
      end
    end else if (reg_write && (write_reg != ZERO_IDX)) begin
      regs_r[write_reg] <= write_data;
    end
  end

  // Forwarding is only meaningful when the write will actually land; while
  // reset is held low the write is discarded, so nothing is forwarded.
  always_comb begin
    fwd_en_s = 1'b0;
    if ((BYPASS != 0) && reset && reg_write) begin
      fwd_en_s = 1'b1;
    end else begin
      fwd_en_s = 1'b0;
    end
  end

  // Read port 1: r0 reads zero, then forwarding, then stored value.
  always_comb begin
    rd1_s = {DATA_W{1'b0}};
    if (read_reg1 == ZERO_IDX) begin
      rd1_s = {DATA_W{1'b0}};
    end else if (fwd_en_s && (write_reg == read_reg1)) begin
      rd1_s = write_data;
    end else begin
      rd1_s = regs_r[read_reg1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rd2_s = {DATA_W{1'b0}};
    if (read_reg2 == ZERO_IDX) begin
      rd2_s = {DATA_W{1'b0}};
    end else if (fwd_en_s && (write_reg == read_reg2)) begin
      rd2_s = write_data;
    end else begin
      rd2_s = regs_r[read_reg2];
    end
  end

  assign read_data1 = rd1_s;
  assign read_data2 = rd2_s;

  // Stack/return taps come straight from storage so stack logic never sees
  // a value that has not been committed yet.
  assign sp_out = regs_r[SP_IDX];
  assign ra_out = regs_r[RA_IDX];

endmodule

// File: tb/tb_reg_bank_rw.sv
module tb_reg_bank_rw;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] rd1_bp, rd2_bp, sp_bp, ra_bp;
  logic [31:0] rd1_nb, rd2_nb, sp_nb, ra_nb;

  int vectors;
  int miscompares;

  logic [31:0] model [32];

  localparam logic [31:0] SP_RST = 32'd227;
  localparam logic [31:0] RA_RST = 32'd0;

  reg_bank_rw #(.DATA_W(32), .SP_INIT(32'd227), .RA_INIT(32'd0), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_bp), .read_data2(rd2_bp), .sp_out(sp_bp), .ra_out(ra_bp)
  );

  reg_bank_rw #(.DATA_W(32), .SP_INIT(32'd227), .RA_INIT(32'd0), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_nb), .read_data2(rd2_nb), .sp_out(sp_nb), .ra_out(ra_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model[29] = SP_RST;
    model[31] = RA_RST;
  endtask

  // Expected read value: r0 is zero; a pending accepted write is visible
  // only with forwarding; otherwise the committed value.
  function automatic logic [31:0] exp_read(input logic [4:0] idx, input bit fwd);
    if (idx == 5'd0) return 32'd0;
    if (fwd && reset && reg_write && (write_reg == idx)) return write_data;
    return model[idx];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    #1;
    check({tag, "/bp_rd1"}, rd1_bp, exp_read(read_reg1, 1'b1));
    check({tag, "/bp_rd2"}, rd2_bp, exp_read(read_reg2, 1'b1));
    check({tag, "/nb_rd1"}, rd1_nb, exp_read(read_reg1, 1'b0));
    check({tag, "/nb_rd2"}, rd2_nb, exp_read(read_reg2, 1'b0));
    check({tag, "/bp_sp"},  sp_bp,  model[29]);
    check({tag, "/bp_ra"},  ra_bp,  model[31]);
    check({tag, "/nb_sp"},  sp_nb,  model[29]);
    check({tag, "/nb_ra"},  ra_nb,  model[31]);
  endtask

  // Advance one rising edge; commit the write to the model if it is accepted.
  task automatic tick();
    @(posedge clk);
    if (reset && reg_write && (write_reg != 5'd0)) model[write_reg] = write_data;
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    reg_write  = we;
    write_reg  = wr;
    write_data = wd;
    read_reg1  = r1;
    read_reg2  = r2;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    model_reset();
    drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd31);

    // Reset state with clock running
    tick();
    check_all("rst_init");
    check("rst_sp_const", sp_bp, 32'd227);
    check("rst_rd1_29", rd1_bp, 32'd227);
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd31);
    check_all("rst_r5");
    // Writes while reset is low are ignored
    drive(1'b1, 5'd5, 32'hAAAA_5555, 5'd29, 5'd31);
    tick();
    tick();
    check_all("rst_wr_ign");
    drive(1'b0, 5'd29, 32'd0, 5'd5, 5'd29);
    check_all("rst_wr_ign_r5");
    check("rst_r5_const", rd1_bp, 32'd0);

    // Release reset between edges
    reset = 1'b1;
    check_all("rel");

    // Basic write/read
    drive(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd0);
    tick();
    drive(1'b0, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd0);
    check_all("wr8");
    check("wr8_const", rd1_nb, 32'hDEAD_BEEF);
    drive(1'b1, 5'd9, 32'h1234_5678, 5'd8, 5'd9);
    tick();
    reg_write = 1'b0;
    check_all("wr9");
    check("wr9_const", rd2_nb, 32'h1234_5678);

    // Zero register
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    check_all("zero_pre");
    tick();
    check_all("zero_post");
    check("zero_const", rd1_bp, 32'd0);

    // Bypass vs no bypass
    drive(1'b1, 5'd10, 32'h11, 5'd10, 5'd10);
    tick();
    drive(1'b1, 5'd10, 32'h22, 5'd10, 5'd10);
    check_all("byp_pre");
    check("byp_pre_bp", rd2_bp, 32'h22);
    check("byp_pre_nb", rd2_nb, 32'h11);
    tick();
    check_all("byp_post");
    check("byp_post_nb", rd1_nb, 32'h22);

    // $sp/$ra taps update only after the edge
    drive(1'b1, 5'd29, 32'hDF, 5'd29, 5'd31);
    check_all("sp_pre");
    check("sp_pre_const", sp_bp, 32'd227);
    tick();
    drive(1'b1, 5'd31, 32'h40, 5'd29, 5'd31);
    check_all("ra_pre");
    check("ra_pre_const", ra_bp, 32'd0);
    tick();
    reg_write = 1'b0;
    check_all("spra_post");
    check("sp_post_const", sp_bp, 32'hDF);
    check("ra_post_const", ra_bp, 32'h40);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom,
            5'($urandom), 5'($urandom));
      if ($urandom_range(0, 3) == 0) read_reg1 = write_reg;
      if ($urandom_range(0, 3) == 0) read_reg2 = write_reg;
      check_all("rnd_pre");
      tick();
      check_all("rnd_post");
    end

    // Mid-operation reset: fill, then short pulse between edges
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i), 5'(i), 5'd0);
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 5'd17, 5'd30);
    check_all("fill");
    check("fill_r17", rd1_bp, 32'd17);
    reset = 1'b0;
    model_reset();
    check_all("pulse_lo");
    check("pulse_r17", rd1_nb, 32'd0);
    #1;
    reset = 1'b1;
    check_all("pulse_rel");

    // Write presented on an edge while reset is low is lost
    drive(1'b1, 5'd7, 32'h77, 5'd29, 5'd31);
    reset = 1'b0;
    tick();
    check_all("rst_edge");
    reset = 1'b1;
    drive(1'b0, 5'd7, 32'h77, 5'd7, 5'd7);
    check_all("rst_edge_r7");
    check("rst_edge_r7_const", rd1_bp, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
